// File: rtl/mult_booth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_booth_pkg
//  Description : Shared types for the sequential radix-2 Booth multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mult_state_e;

    typedef struct packed {
        logic load;
        logic iterate;
        logic capture;
    } mult_ctrl_t;

    typedef enum logic [1:0] {
        BOOTH_NOP = 2'd0,
        BOOTH_ADD = 2'd1,
        BOOTH_SUB = 2'd2
    } booth_op_e;

    // pair = {Q[0], Q_1}
    function automatic booth_op_e booth_op(input logic [1:0] pair);
        case (pair)
            2'b01:   return BOOTH_ADD;
            2'b10:   return BOOTH_SUB;
            default: return BOOTH_NOP;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_booth_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : mult_booth_seq_if
//  Description : Operand/result handshake bundle of the Booth multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mult_booth_seq_if #(
    parameter int N = 8
) ();
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           signed_mode;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] y;
    logic           busy;

    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, y, busy
    );

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, y, busy
    );
endinterface
`default_nettype wire

// File: rtl/mult_booth_dp.sv
`default_nettype none
// ============================================================================
//  Module      : mult_booth_dp
//  Description : Booth datapath - M/acc/Q/Q_1 registers, add/sub, arithmetic
//                shift and result register, sequenced by mult_ctrl_t.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_booth_dp
    import mult_booth_pkg::*;
#(
    parameter int N = 8
) (
    input  wire logic           clk,
    input  wire logic           rst,
    input  wire mult_ctrl_t     ctrl,
    input  wire logic [N-1:0]   a,
    input  wire logic [N-1:0]   b,
    input  wire logic           signed_mode,
    output logic [2*N-1:0]      y
);
    localparam int c_w = N + 1;

    logic [c_w-1:0] r_m;
    logic [c_w-1:0] r_acc;
    logic [c_w-1:0] r_q;
    logic           r_q_1;
    logic [2*N-1:0] r_y;

    logic [c_w-1:0] w_sum;
    logic [c_w-1:0] w_acc_sh;
    logic [c_w-1:0] w_q_sh;
    logic [2*N-1:0] w_prod;

    always_comb begin
        w_sum = r_acc;
        case (booth_op({r_q[0], r_q_1}))
            BOOTH_ADD: w_sum = r_acc + r_m;
            BOOTH_SUB: w_sum = r_acc - r_m;
            default:   w_sum = r_acc;
        endcase
        w_acc_sh = {w_sum[c_w-1], w_sum[c_w-1:1]};
        w_q_sh   = {w_sum[0], r_q[c_w-1:1]};
        // Low 2N bits of the post-shift {acc,Q}; the top two bits are pure sign.
        w_prod   = {w_acc_sh[c_w-3:0], w_q_sh};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m   <= '0;
            r_acc <= '0;
            r_q   <= '0;
            r_q_1 <= 1'b0;
            r_y   <= '0;
        end else begin
            if (ctrl.load) begin
                r_m   <= signed_mode ? {a[N-1], a} : {1'b0, a};
                r_q   <= signed_mode ? {b[N-1], b} : {1'b0, b};
                r_acc <= '0;
                r_q_1 <= 1'b0;
            end else if (ctrl.iterate) begin
                r_acc <= w_acc_sh;
                r_q   <= w_q_sh;
                r_q_1 <= r_q[0];
            end
            // A capture without an iteration is the zero-operand shortcut.
            if (ctrl.capture) begin
                r_y <= ctrl.iterate ? w_prod : '0;
            end
        end
    end

    assign y = r_y;

endmodule
`default_nettype wire

// File: rtl/mult_booth_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mult_booth_seq
//  Description : Self-sequenced radix-2 Booth multiplier with valid/ready on
//                both sides. Optional MULT_BOOTH_ZERO_BYPASS_EN shortcuts a
//                zero operand straight to DONE with y=0.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_booth_seq
    import mult_booth_pkg::*;
#(
    parameter int N = 8
) (
    input  wire logic       clk,
    input  wire logic       rst,
    mult_booth_seq_if.slave bus
);
    localparam int                 c_cnt_w = $clog2(N + 2);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(N);

    mult_state_e        r_state;
    mult_state_e        w_state_next;
    mult_ctrl_t         w_ctrl;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2*N-1:0]     w_y;

`ifdef MULT_BOOTH_ZERO_BYPASS_EN
    logic r_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_zero <= 1'b0;
        end else if (w_ctrl.load) begin
            r_zero <= (bus.a == '0) || (bus.b == '0);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_ctrl.load) begin
                r_cnt <= '0;
            end else if (w_ctrl.iterate) begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ctrl       = '0;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_ctrl.load  = 1'b1;
                    w_state_next = CALC;
                end
            end
            CALC: begin
`ifdef MULT_BOOTH_ZERO_BYPASS_EN
                // Zero operand: one CALC cycle to register y=0, no iterations.
                if (r_zero) begin
                    w_ctrl.capture = 1'b1;
                    w_state_next   = DONE;
                end else
`endif
                begin
                    w_ctrl.iterate = 1'b1;
                    if (r_cnt == c_last) begin
                        w_ctrl.capture = 1'b1;
                        w_state_next   = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    mult_booth_dp #(
        .N (N)
    ) u_dp (
        .clk         (clk),
        .rst         (rst),
        .ctrl        (w_ctrl),
        .a           (bus.a),
        .b           (bus.b),
        .signed_mode (bus.signed_mode),
        .y           (w_y)
    );

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.busy      = (r_state == CALC) || (r_state == DONE);
    assign bus.y         = w_y;

endmodule
`default_nettype wire

// File: tb/tb_mult_booth_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_booth_seq
//  Description : Directed self-checking bench for mult_booth_seq (N=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_booth_seq;
    localparam int N     = 8;
    localparam int c_lat = N + 2;
`ifdef MULT_BOOTH_ZERO_BYPASS_EN
    localparam int c_zero_lat = 2;
`else
    localparam int c_zero_lat = N + 2;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    mult_booth_seq_if #(.N(N)) bus ();

    mult_booth_seq #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one operation, then waits (bounded) for out_valid.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic sm, input logic [15:0] exp_y, input int exp_lat);
        int cyc;
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid    = 1'b1;
        bus.a           = a;
        bus.b           = b;
        bus.signed_mode = sm;
        tick();
        cyc = 1;
        // Operand changes after acceptance must not disturb the result.
        bus.in_valid    = 1'b0;
        bus.a           = ~a;
        bus.b           = ~b;
        bus.signed_mode = ~sm;
        chk({tag, "_busy"}, {bus.busy, bus.in_ready}, 32'b10);
        while (bus.out_valid !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        chk({tag, "_y"}, 32'(bus.y), 32'(exp_y));
    endtask

    // With out_ready high, DONE lasts one cycle; y must stay afterwards.
    task automatic release_op(input string tag, input logic [15:0] exp_y);
        tick();
        chk({tag, "_idle"}, {bus.out_valid, bus.in_ready, bus.busy}, 32'b010);
        chk({tag, "_y_hold"}, 32'(bus.y), 32'(exp_y));
    endtask

    initial begin
        bit seen;
        bus.in_valid    = 1'b0;
        bus.a           = '0;
        bus.b           = '0;
        bus.signed_mode = 1'b0;
        bus.out_ready   = 1'b1;

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_flags", {bus.out_valid, bus.in_ready, bus.busy}, 32'b010);
        chk("reset_y", 32'(bus.y), 32'h0);

        // Signed
        run_op("s_m3x5", 8'hFD, 8'h05, 1'b1, 16'hFFF1, c_lat);
        release_op("s_m3x5", 16'hFFF1);
        run_op("s_m128xm128", 8'h80, 8'h80, 1'b1, 16'h4000, c_lat);
        release_op("s_m128xm128", 16'h4000);
        run_op("s_127xm128", 8'h7F, 8'h80, 1'b1, 16'hC080, c_lat);
        release_op("s_127xm128", 16'hC080);
        run_op("s_m1xm1", 8'hFF, 8'hFF, 1'b1, 16'h0001, c_lat);
        release_op("s_m1xm1", 16'h0001);
        run_op("s_127x127", 8'h7F, 8'h7F, 1'b1, 16'h3F01, c_lat);
        release_op("s_127x127", 16'h3F01);

        // Unsigned
        run_op("u_255x255", 8'hFF, 8'hFF, 1'b0, 16'hFE01, c_lat);
        release_op("u_255x255", 16'hFE01);
        run_op("u_128x2", 8'h80, 8'h02, 1'b0, 16'h0100, c_lat);
        release_op("u_128x2", 16'h0100);
        run_op("u_253x5", 8'hFD, 8'h05, 1'b0, 16'h04F1, c_lat);
        release_op("u_253x5", 16'h04F1);

        // Back-pressure: result held, new requests refused
        bus.out_ready = 1'b0;
        run_op("bp", 8'h0C, 8'h0B, 1'b0, 16'h0084, c_lat);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = 8'h01;
            bus.b        = 8'h01;
            tick();
            chk("bp_hold_flags", {bus.out_valid, bus.in_ready, bus.busy}, 32'b101);
            chk("bp_hold_y", 32'(bus.y), 32'h0084);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("bp_release", {bus.out_valid, bus.in_ready, bus.busy}, 32'b010);
        run_op("bp_next", 8'hFA, 8'h03, 1'b1, 16'hFFEE, c_lat);
        release_op("bp_next", 16'hFFEE);

        // Reset in the middle of CALC
        bus.in_valid    = 1'b1;
        bus.a           = 8'h12;
        bus.b           = 8'h34;
        bus.signed_mode = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_flags", {bus.out_valid, bus.in_ready, bus.busy}, 32'b010);
        chk("rst_mid_y", 32'(bus.y), 32'h0);
        seen = 1'b0;
        repeat (15) begin
            tick();
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        chk("rst_no_valid", 32'(seen), 32'd0);
        run_op("rst_7x9", 8'h07, 8'h09, 1'b0, 16'h003F, c_lat);
        release_op("rst_7x9", 16'h003F);

        // Zero operands
        run_op("zero_a", 8'h00, 8'h55, 1'b0, 16'h0000, c_zero_lat);
        release_op("zero_a", 16'h0000);
        run_op("mid_5x5", 8'h05, 8'h05, 1'b0, 16'h0019, c_lat);
        release_op("mid_5x5", 16'h0019);
        run_op("zero_b", 8'h9C, 8'h00, 1'b1, 16'h0000, c_zero_lat);
        release_op("zero_b", 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
